// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding,
// supported opcodes, ALU operation classes, ALU function codes and the
// control-word payload driven toward the datapath.
package mips_mc_controller_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_OP_W  = 2;
    localparam int unsigned ALU_SEL_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } mc_state_t;

    // Supported opcodes (instruction register [31:26])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    // ALU operation class handed to the ALU decoder
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

    // R-type funct field values
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    // ALU function select codes
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_SEL_W-1:0] ALU_NOR = 4'b1100;

    // Datapath control word decoded from the current state
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory bundle. The controller side uses the
// master modport, the datapath side uses the slave modport.
interface mips_mc_controller_if;
    import mips_mc_controller_pkg::*;

    logic [OPCODE_W-1:0]  opcode;
    logic [FUNCT_W-1:0]   funct;
    logic                 zero;
    logic                 mem_ready;

    logic                 mem_req;
    logic                 mem_we;
    logic                 iord;
    logic                 ir_write;
    logic                 pc_en;
    logic [1:0]           pc_src;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 reg_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 instr_done;
    logic                 illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
               mem_to_reg, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
               mem_to_reg, instr_done, illegal_op
    );

endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// ALU decoder: maps the controller's ALU operation class plus the R-type
// funct field onto the ALU function select.
module mips_mc_controller_alu_decoder
    import mips_mc_controller_pkg::*;
(
    input  logic [ALU_OP_W-1:0]  alu_op,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALU_SEL_W-1:0] alu_sel_c
);

    // Unknown funct codes fall back to add so the ALU never sees an undefined select
    always_comb begin
        alu_sel_c = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_sel_c = ALU_ADD;
            ALU_OP_SUB: alu_sel_c = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_sel_c = ALU_ADD;
                    FN_SUB:  alu_sel_c = ALU_SUB;
                    FN_AND:  alu_sel_c = ALU_AND;
                    FN_OR:   alu_sel_c = ALU_OR;
                    FN_NOR:  alu_sel_c = ALU_NOR;
                    FN_SLT:  alu_sel_c = ALU_SLT;
                    default: alu_sel_c = ALU_ADD;
                endcase
            end
            default: alu_sel_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle sequencing controller for the MIPS core. Steps each
// instruction through fetch/decode/execute/memory/writeback states and
// drives all datapath enables and selects from the registered state.
// Outputs are combinational from the state (plus mem_ready/zero) so the
// datapath sees them in the same cycle; rst forces all of them low.
// Optional feature: define MIPS_MC_ILLEGAL_TRAP_EN to send unsupported
// opcodes to a sticky TRAP state; otherwise they retire as a 2-cycle NOP.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mips_mc_controller_if.master bus
);

    mc_state_t            state_q;
    mc_state_t            state_d;
    ctrl_t                ctrl_c;
    ctrl_t                ctrl_out_c;
    logic [ALU_OP_W-1:0]  alu_op_c;
    logic [ALU_SEL_W-1:0] alu_sel_c;
    logic                 out_en_c;
    logic                 illegal_flag;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    // Sticky unsupported-opcode flag, set on the DECODE -> TRAP edge
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_flag <= 1'b0;
        end else if ((state_q == S_DECODE) && (state_d == S_TRAP)) begin
            illegal_flag <= 1'b1;
        end
    end
`else
    assign illegal_flag = 1'b0;
`endif

    // ALU function select from operation class and funct
    mips_mc_controller_alu_decoder u_alu_decoder (
        .alu_op    (alu_op_c),
        .funct     (bus.funct),
        .alu_sel_c (alu_sel_c)
    );

    // Next-state and per-state control word
    always_comb begin
        state_d  = state_q;
        ctrl_c   = '0;
        alu_op_c = ALU_OP_ADD;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_en    = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        ctrl_c.instr_done = 1'b1;
                        state_d           = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_we  = 1'b1;
                ctrl_c.iord    = 1'b1;
                if (bus.mem_ready) begin
                    ctrl_c.instr_done = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                alu_op_c         = ALU_OP_FUNCT;
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
            S_BEQ: begin
                ctrl_c.alu_src_a  = 1'b1;
                alu_op_c          = ALU_OP_SUB;
                ctrl_c.pc_src     = 2'b01;
                ctrl_c.pc_en      = bus.zero;
                ctrl_c.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
            S_ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_d          = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_src     = 2'b10;
                ctrl_c.pc_en      = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output gating: nothing reaches the datapath during reset or in TRAP
    assign out_en_c   = !rst && (state_q != S_TRAP);
    assign ctrl_out_c = out_en_c ? ctrl_c : '0;

    assign bus.mem_req    = ctrl_out_c.mem_req;
    assign bus.mem_we     = ctrl_out_c.mem_we;
    assign bus.iord       = ctrl_out_c.iord;
    assign bus.ir_write   = ctrl_out_c.ir_write;
    assign bus.pc_en      = ctrl_out_c.pc_en;
    assign bus.pc_src     = ctrl_out_c.pc_src;
    assign bus.alu_src_a  = ctrl_out_c.alu_src_a;
    assign bus.alu_src_b  = ctrl_out_c.alu_src_b;
    assign bus.reg_write  = ctrl_out_c.reg_write;
    assign bus.reg_dst    = ctrl_out_c.reg_dst;
    assign bus.mem_to_reg = ctrl_out_c.mem_to_reg;
    assign bus.instr_done = ctrl_out_c.instr_done;
    assign bus.alu_sel    = out_en_c ? alu_sel_c : '0;
    assign bus.illegal_op = illegal_flag & ~rst;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller. Each instruction is expanded
// by a reference model into its expected per-cycle control outputs (given
// the memory stall pattern) and compared cycle by cycle against the DUT.
module tb_mips_mc_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_controller_if bus ();

    mips_mc_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOR = 4'b1100;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_sel;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       zero;
        outs_t      exp;
    } step_t;

    int    checks   = 0;
    int    failures = 0;
    step_t seq[$];
    logic [5:0] b_op;
    logic [5:0] b_fn;

    function automatic logic [3:0] funct_code(input logic [5:0] f);
        case (f)
            6'b100000: return SEL_ADD;
            6'b100010: return SEL_SUB;
            6'b100100: return SEL_AND;
            6'b100101: return SEL_OR;
            6'b101010: return SEL_SLT;
            6'b100111: return SEL_NOR;
            default:   return SEL_ADD;
        endcase
    endfunction

    function automatic bit known(input logic [5:0] op);
        return op inside {OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Idle control word: everything low, ALU defaults to add
    function automatic outs_t base();
        outs_t o;
        o = '0;
        o.alu_sel = SEL_ADD;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.mem_req    = bus.mem_req;
        o.mem_we     = bus.mem_we;
        o.iord       = bus.iord;
        o.ir_write   = bus.ir_write;
        o.pc_en      = bus.pc_en;
        o.pc_src     = bus.pc_src;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_sel    = bus.alu_sel;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.instr_done = bus.instr_done;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    task automatic push(input logic rdy, input logic z, input outs_t e);
        step_t s;
        s.op = b_op; s.fn = b_fn; s.rdy = rdy; s.zero = z; s.exp = e;
        seq.push_back(s);
    endtask

    // Reference model: expected cycle-by-cycle behaviour of one instruction
    task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input int fstall, input int mstall);
        outs_t o;
        b_op = op; b_fn = fn;
        for (int i = 0; i < fstall; i++) begin
            o = base(); o.mem_req = 1'b1; o.alu_src_b = 2'b01;
            push(1'b0, rb(), o);
        end
        o = base(); o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = 1'b1; o.pc_en = 1'b1;
        push(1'b1, rb(), o);
        o = base(); o.alu_src_b = 2'b11;
        if (!known(op) && !TRAP_EN) o.instr_done = 1'b1;
        push(rb(), rb(), o);
        if (!known(op)) return;
        case (op)
            OPC_LW, OPC_SW: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(rb(), rb(), o);
                o = base(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == OPC_SW);
                for (int i = 0; i < mstall; i++) push(1'b0, rb(), o);
                if (op == OPC_LW) begin
                    push(1'b1, rb(), o);
                    o = base(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
                    push(rb(), rb(), o);
                end else begin
                    o.instr_done = 1'b1;
                    push(1'b1, rb(), o);
                end
            end
            OPC_R: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_sel = funct_code(fn);
                push(rb(), rb(), o);
                o = base(); o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
                push(rb(), rb(), o);
            end
            OPC_BEQ: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_sel = SEL_SUB; o.pc_src = 2'b01;
                o.pc_en = z; o.instr_done = 1'b1;
                push(rb(), z, o);
            end
            OPC_ADDI: begin
                o = base(); o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(rb(), rb(), o);
                o = base(); o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(rb(), rb(), o);
            end
            default: begin
                o = base(); o.pc_src = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
                push(rb(), rb(), o);
            end
        endcase
    endtask

    // Apply one cycle of inputs just after the edge, sample mid-cycle
    task automatic run_step(input step_t s, output outs_t got);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.opcode    = s.op;
        bus.funct     = s.fn;
        bus.zero      = s.zero;
        bus.mem_ready = s.rdy;
        @(negedge clk);
        got = sample();
    endtask

    // One cycle with rst high and arbitrary inputs
    task automatic reset_cycle(output outs_t got);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.opcode    = 6'($urandom);
        bus.funct     = 6'($urandom);
        bus.zero      = rb();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        got = sample();
    endtask

    task automatic test_reset();
        outs_t got;
        for (int i = 0; i < 3; i++) begin
            reset_cycle(got);
            checks++;
            if (got !== outs_t'(0)) begin
                failures++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, got, outs_t'(0));
            end
        end
        seq.delete();
        build_instr(OPC_J, 6'($urandom), 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL after_reset_j cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
    endtask

    task automatic test_lw();
        outs_t got;
        int    done_cnt;
        done_cnt = 0;
        seq.delete();
        build_instr(OPC_LW, 6'($urandom), 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            done_cnt += int'(got.instr_done);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL lw cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL lw_instr_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_sw_stall();
        outs_t got;
        seq.delete();
        build_instr(OPC_SW, 6'($urandom), 1'b0, 0, 2);
        build_instr(OPC_ADDI, 6'($urandom), 1'b0, 1, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL sw_stall cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
    endtask

    task automatic test_beq();
        outs_t got;
        seq.delete();
        build_instr(OPC_BEQ, 6'($urandom), 1'b1, 0, 0);
        build_instr(OPC_BEQ, 6'($urandom), 1'b0, 0, 0);
        build_instr(OPC_J,   6'($urandom), 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL beq cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
    endtask

    task automatic test_rtype();
        outs_t      got;
        logic [5:0] fns [6];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        seq.delete();
        foreach (fns[k]) build_instr(OPC_R, fns[k], 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL rtype cyc%0d fn=%b got=%h exp=%h", i, seq[i].fn, got, seq[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        outs_t got;
        seq.delete();
        build_instr(OPC_LW, 6'($urandom), 1'b0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
        reset_cycle(got);
        checks++;
        if (got !== outs_t'(0)) begin
            failures++;
            $display("FAIL rst_mid_cycle got=%h exp=%h", got, outs_t'(0));
        end
        seq.delete();
        build_instr(OPC_ADDI, 6'($urandom), 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL rst_mid_post cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        outs_t got;
        seq.delete();
        build_instr(OPC_BAD, 6'($urandom), 1'b0, 0, 0);
        if (!TRAP_EN) build_instr(OPC_ADDI, 6'($urandom), 1'b0, 0, 0);
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, seq[i].exp);
            end
        end
        if (TRAP_EN) begin
            outs_t trap_exp;
            step_t s;
            trap_exp = '0;
            trap_exp.illegal_op = 1'b1;
            for (int i = 0; i < 5; i++) begin
                s.op = 6'($urandom); s.fn = 6'($urandom); s.rdy = rb(); s.zero = rb();
                s.exp = trap_exp;
                run_step(s, got);
                checks++;
                if (got !== trap_exp) begin
                    failures++;
                    $display("FAIL trap_hold cyc%0d got=%h exp=%h", i, got, trap_exp);
                end
            end
            reset_cycle(got);
            checks++;
            if (got !== outs_t'(0)) begin
                failures++;
                $display("FAIL trap_reset got=%h exp=%h", got, outs_t'(0));
            end
            seq.delete();
            build_instr(OPC_J, 6'($urandom), 1'b0, 0, 0);
            foreach (seq[i]) begin
                run_step(seq[i], got);
                checks++;
                if (got !== seq[i].exp) begin
                    failures++;
                    $display("FAIL trap_recover cyc%0d got=%h exp=%h", i, got, seq[i].exp);
                end
            end
        end
    endtask

    task automatic test_random();
        outs_t      got;
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{OPC_R, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J};
        seq.delete();
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 5)];
            if (!TRAP_EN && ($urandom_range(0, 5) == 0)) op = 6'($urandom);
            build_instr(op, 6'($urandom), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        foreach (seq[i]) begin
            run_step(seq[i], got);
            checks++;
            if (got !== seq[i].exp) begin
                failures++;
                $display("FAIL random cyc%0d op=%b got=%h exp=%h", i, seq[i].op, got, seq[i].exp);
            end
        end
    endtask

    initial begin
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
